// File: rtl/control_mc_pkg.sv
// Shared VeriRISC types for the multi-cycle sequencer: opcodes, sequencer states, ALU-op test.
package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    INST_ADDR,
    INST_FETCH,
    INST_LOAD,
    IDLE,
    OP_ADDR,
    OP_FETCH,
    ALU_OP,
    STORE,
    HALTED
  } state_t;

  // Opcodes that read an operand from memory into the accumulator.
  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/control_mc_if.sv
// Strobe/handshake bundle between control_mc (master) and the datapath/memory side (slave).
interface control_mc_if #(
  parameter int unsigned CNT_W = 16
) ();
  typedefs::opcode_t opcode;
  logic              zero;
  logic              mem_ack;
  logic              resume;
  logic              mem_rd;
  logic              load_ir;
  logic              halt;
  logic              inc_pc;
  logic              load_ac;
  logic              load_pc;
  logic              mem_wr;
  logic              bus_err;
  logic [CNT_W-1:0]  icount;

  modport master (
    input  opcode, zero, mem_ack, resume,
    output mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, bus_err, icount
  );

  modport slave (
    output opcode, zero, mem_ack, resume,
    input  mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, bus_err, icount
  );
endinterface

// File: rtl/control_mc_wait_timer.sv
// Consecutive stall-cycle counter; expired stays high once TIMEOUT stalls accumulate until cleared.
module ctrl_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic clear,
  output logic expired
);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (stall && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == CntW'(TIMEOUT));
endmodule

// File: rtl/control_mc.sv
// VeriRISC multi-cycle sequencer: seven control strobes, latched halt/resume, retire counter.
// Define CTRL_WAIT_EN to add memory wait states, stall timeout and the sticky bus_err flag.
module control_mc
  import typedefs::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input logic          clk,
  input logic          rst,
  control_mc_if.master bus
);
  state_t           r_state;
  logic [CNT_W-1:0] r_icount;
  logic             r_bus_err;
  logic             w_aluop;
  logic             w_stall;
  logic             w_expired;

  assign w_aluop = is_aluop(bus.opcode);

`ifdef CTRL_WAIT_EN
  logic w_wait_phase;
  logic w_clear;

  assign w_wait_phase = (r_state == INST_FETCH) || (r_state == OP_FETCH && w_aluop) ||
                        (r_state == STORE && bus.opcode == STO);
  assign w_stall      = w_wait_phase && !bus.mem_ack;
  // Any non-stalled cycle ends the consecutive-stall run.
  assign w_clear      = !w_stall;
  assign bus.bus_err  = r_bus_err;

  ctrl_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .stall  (w_stall),
    .clear  (w_clear),
    .expired(w_expired)
  );
`else
  logic w_unused;

  assign w_stall     = 1'b0;
  assign w_expired   = 1'b0;
  assign bus.bus_err = 1'b0;
  assign w_unused    = bus.mem_ack ^ r_bus_err ^ (TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= INST_ADDR;
      r_icount  <= '0;
      r_bus_err <= 1'b0;
    end else if (w_expired) begin
      r_state   <= HALTED;
      r_bus_err <= 1'b1;
    end else if (!w_stall) begin
      case (r_state)
        INST_ADDR:  r_state <= INST_FETCH;
        INST_FETCH: r_state <= INST_LOAD;
        INST_LOAD:  r_state <= IDLE;
        IDLE:       r_state <= OP_ADDR;
        OP_ADDR:    r_state <= (bus.opcode == HLT) ? HALTED : OP_FETCH;
        OP_FETCH:   r_state <= ALU_OP;
        ALU_OP:     r_state <= STORE;
        STORE: begin
          r_state  <= INST_ADDR;
          r_icount <= r_icount + 1'b1;
        end
        HALTED: begin
          if (bus.resume) begin
            r_state   <= INST_ADDR;
            r_bus_err <= 1'b0;
          end
        end
        default:    r_state <= INST_ADDR;
      endcase
    end
  end

  always_comb begin
    bus.mem_rd  = 1'b0;
    bus.load_ir = 1'b0;
    bus.halt    = 1'b0;
    bus.inc_pc  = 1'b0;
    bus.load_ac = 1'b0;
    bus.load_pc = 1'b0;
    bus.mem_wr  = 1'b0;
    case (r_state)
      INST_FETCH: bus.mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        bus.mem_rd  = 1'b1;
        bus.load_ir = 1'b1;
      end
      OP_ADDR: begin
        bus.inc_pc = 1'b1;
        bus.halt   = (bus.opcode == HLT);
      end
      OP_FETCH:   bus.mem_rd = w_aluop;
      ALU_OP: begin
        bus.mem_rd  = w_aluop;
        bus.load_ac = w_aluop;
        bus.inc_pc  = (bus.opcode == SKZ) && bus.zero;
        bus.load_pc = (bus.opcode == JMP);
      end
      STORE: begin
        bus.mem_rd  = w_aluop;
        bus.load_ac = w_aluop;
        bus.inc_pc  = (bus.opcode == JMP);
        bus.load_pc = (bus.opcode == JMP);
        bus.mem_wr  = (bus.opcode == STO);
      end
      HALTED:     bus.halt = 1'b1;
      default:    ;
    endcase
  end

  assign bus.icount = r_icount;
endmodule

// File: tb/tb_control_mc.sv
// Self-checking bench for control_mc: instruction-level reference model plus directed scenarios.
module tb_control_mc;
  import typedefs::*;

  localparam int unsigned TIMEOUT = 15;
`ifdef CTRL_WAIT_EN
  localparam bit WaitEn = 1'b1;
`else
  localparam bit WaitEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_mc_if #(.CNT_W(16)) bus ();
  control_mc_if #(.CNT_W(4))  bus4 ();

  assign bus4.opcode  = bus.opcode;
  assign bus4.zero    = bus.zero;
  assign bus4.mem_ack = bus.mem_ack;
  assign bus4.resume  = bus.resume;

  control_mc #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  control_mc #(.TIMEOUT(TIMEOUT), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
  logic [6:0] strobes;
  assign strobes = {bus.mem_rd, bus.load_ir, bus.halt, bus.inc_pc, bus.load_ac, bus.load_pc,
                    bus.mem_wr};

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: position within the 8-phase instruction, halted flag, retired count.
  int          m_ph;
  bit          m_halted;
  logic [15:0] m_icount;
  bit          m_bus_err;
  int          m_stall;

  function automatic logic [6:0] exp_strobes();
    opcode_t op;
    logic    alu;
    op  = bus.opcode;
    alu = op inside {ADD, AND, XOR, LDA};
    if (m_halted) return 7'b0010000;
    case (m_ph)
      1:       return 7'b1000000;
      2, 3:    return 7'b1100000;
      4:       return {2'b00, op == HLT, 1'b1, 3'b000};
      5:       return {alu, 6'b000000};
      6:       return {alu, 2'b00, (op == SKZ) && bus.zero, alu, op == JMP, 1'b0};
      7:       return {alu, 2'b00, op == JMP, alu, op == JMP, op == STO};
      default: return 7'b0000000;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic alu;
    logic wph;
    alu = bus.opcode inside {ADD, AND, XOR, LDA};
    wph = WaitEn && !m_halted &&
          (m_ph == 1 || (m_ph == 5 && alu) || (m_ph == 7 && bus.opcode == STO));
    if (rst) begin
      m_ph = 0; m_halted = 0; m_icount = '0; m_bus_err = 0; m_stall = 0;
    end else if (WaitEn && m_stall == int'(TIMEOUT)) begin
      m_halted = 1; m_bus_err = 1; m_stall = 0;
    end else if (wph && !bus.mem_ack) begin
      m_stall++;
    end else begin
      m_stall = 0;
      if (m_halted) begin
        if (bus.resume) begin
          m_halted = 0; m_ph = 0; m_bus_err = 0;
        end
      end else if (m_ph == 4 && bus.opcode == HLT) begin
        m_halted = 1;
      end else if (m_ph == 7) begin
        m_ph = 0; m_icount++;
      end else begin
        m_ph++;
      end
    end
  endtask

  task automatic drive(opcode_t op, logic z, logic ack, logic res);
    bus.opcode = op; bus.zero = z; bus.mem_ack = ack; bus.resume = res;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(ADD, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++;
    if (strobes !== 7'b0) $display("FAIL reset_strobes got=%b want=%b", strobes, 7'b0);
    else n_pass++;
    n_total++;
    if (bus.icount !== 16'd0) $display("FAIL reset_icount got=%0d want=0", bus.icount);
    else n_pass++;
    n_total++;
    if (bus4.icount !== 4'd0) $display("FAIL reset_icount4 got=%0d want=0", bus4.icount);
    else n_pass++;
    n_total++;
    if (bus.bus_err !== 1'b0) $display("FAIL reset_bus_err got=%b want=0", bus.bus_err);
    else n_pass++;
  endtask

  task automatic test_all_opcodes();
    opcode_t op;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      op = opcode_t'(1 + (i % 7));
      for (int c = 0; c < 8; c++) begin
        drive(op, logic'((i / 7) % 2), 1'b1, 1'b0);
        #1;
        n_total++;
        if (strobes !== exp_strobes() || bus.icount !== m_icount || bus.bus_err !== m_bus_err)
          $display("FAIL all_ops i=%0d c=%0d strobes=%b want=%b icount=%0d want=%0d",
                   i, c, strobes, exp_strobes(), bus.icount, m_icount);
        else n_pass++;
        tick();
      end
    end
    #1;
    n_total++;
    if (bus.icount !== 16'd16) $display("FAIL all_ops_icount got=%0d want=16", bus.icount);
    else n_pass++;
    n_total++;
    if (bus4.icount !== 4'd0) $display("FAIL all_ops_icount4 got=%0d want=0", bus4.icount);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 17 * 8; c++) begin
      drive(ADD, 1'b0, 1'b1, 1'b0);
      #1;
      n_total++;
      if (bus4.icount !== m_icount[3:0] || strobes !== exp_strobes())
        $display("FAIL wrap c=%0d icount4=%0d want=%0d strobes=%b want=%b",
                 c, bus4.icount, m_icount[3:0], strobes, exp_strobes());
      else n_pass++;
      tick();
    end
    #1;
    n_total++;
    if (bus4.icount !== 4'd1 || bus.icount !== 16'd17)
      $display("FAIL wrap_final icount4=%0d want=1 icount=%0d want=17", bus4.icount, bus.icount);
    else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(ADD, 1'b0, 1'b1, 1'b0);
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      drive(HLT, 1'b0, 1'b1, 1'b0);
      #1;
      n_total++;
      if (strobes !== exp_strobes())
        $display("FAIL halt_seq c=%0d strobes=%b want=%b", c, strobes, exp_strobes());
      else n_pass++;
      if (c == 4) begin
        n_total++;
        if (bus.halt !== 1'b1 || bus.inc_pc !== 1'b1)
          $display("FAIL halt_op_addr halt=%b inc_pc=%b want=1/1", bus.halt, bus.inc_pc);
        else n_pass++;
      end
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      drive(HLT, 1'b0, 1'b1, 1'b0);
      #1;
      n_total++;
      if (strobes !== 7'b0010000 || bus.icount !== 16'd1)
        $display("FAIL halted c=%0d strobes=%b want=0010000 icount=%0d want=1",
                 c, strobes, bus.icount);
      else n_pass++;
      tick();
    end
    drive(ADD, 1'b0, 1'b1, 1'b1);
    tick();
    drive(ADD, 1'b0, 1'b1, 1'b0);
    #1;
    n_total++;
    if (strobes !== 7'b0 || bus.icount !== 16'd1)
      $display("FAIL resume_exit strobes=%b want=0 icount=%0d want=1", strobes, bus.icount);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (strobes !== 7'b1000000) $display("FAIL resume_fetch strobes=%b want=1000000", strobes);
    else n_pass++;
    for (int c = 1; c < 8; c++) tick();
  endtask

  task automatic test_resume_ignored();
    logic [15:0] start;
    start = m_icount;
    for (int c = 0; c < 8; c++) begin
      drive(ADD, 1'b1, 1'b1, logic'(c == 6 || c == 2));
      #1;
      n_total++;
      if (strobes !== exp_strobes())
        $display("FAIL resume_ignored c=%0d strobes=%b want=%b", c, strobes, exp_strobes());
      else n_pass++;
      tick();
    end
    drive(ADD, 1'b0, 1'b1, 1'b0);
    #1;
    n_total++;
    if (strobes !== 7'b0 || bus.icount !== start + 16'd1)
      $display("FAIL resume_ignored_end strobes=%b want=0 icount=%0d want=%0d",
               strobes, bus.icount, start + 16'd1);
    else n_pass++;
  endtask

  task automatic test_no_stall();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(LDA, 1'b0, 1'b0, 1'b0);
      #1;
      n_total++;
      if (strobes !== exp_strobes() || bus.bus_err !== m_bus_err)
        $display("FAIL no_stall c=%0d strobes=%b want=%b bus_err=%b want=%b",
                 c, strobes, exp_strobes(), bus.bus_err, m_bus_err);
      else n_pass++;
      tick();
    end
    #1;
    n_total++;
    if (WaitEn) n_pass++;
    else if (bus.icount !== 16'd1 || bus.bus_err !== 1'b0 || strobes !== 7'b0)
      $display("FAIL no_stall_end icount=%0d want=1 bus_err=%b want=0", bus.icount, bus.bus_err);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic ack;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      ack = !((c >= 1 && c <= 3) || (c >= 8 && c <= 9));
      drive(LDA, 1'b0, ack, 1'b0);
      #1;
      n_total++;
      if (strobes !== exp_strobes() || bus.icount !== m_icount)
        $display("FAIL stall c=%0d strobes=%b want=%b icount=%0d want=%0d",
                 c, strobes, exp_strobes(), bus.icount, m_icount);
      else n_pass++;
      if (c == 3 || c == 9) begin
        n_total++;
        if (strobes !== 7'b1000000) $display("FAIL stall_frozen c=%0d strobes=%b want=1000000",
                                             c, strobes);
        else n_pass++;
      end
      tick();
    end
    #1;
    n_total++;
    if (strobes !== 7'b0 || bus.icount !== 16'd1)
      $display("FAIL stall_13cyc strobes=%b want=0 icount=%0d want=1", strobes, bus.icount);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(STO, 1'b0, 1'b1, 1'b0);
      tick();
    end
    for (int s = 0; s < 16; s++) begin
      drive(STO, 1'b0, 1'b0, 1'b0);
      #1;
      n_total++;
      if (bus.mem_wr !== 1'b1 || strobes !== exp_strobes())
        $display("FAIL timeout_hold s=%0d mem_wr=%b want=1 strobes=%b want=%b",
                 s, bus.mem_wr, strobes, exp_strobes());
      else n_pass++;
      tick();
    end
    drive(STO, 1'b0, 1'b0, 1'b0);
    #1;
    n_total++;
    if (strobes !== 7'b0010000 || bus.bus_err !== 1'b1 || bus.icount !== 16'd0)
      $display("FAIL timeout_halt strobes=%b want=0010000 bus_err=%b want=1", strobes, bus.bus_err);
    else n_pass++;
    drive(STO, 1'b0, 1'b0, 1'b1);
    tick();
    drive(ADD, 1'b0, 1'b1, 1'b0);
    #1;
    n_total++;
    if (strobes !== 7'b0 || bus.bus_err !== 1'b0)
      $display("FAIL timeout_resume strobes=%b want=0 bus_err=%b want=0", strobes, bus.bus_err);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      drive(ADD, 1'b0, 1'b1, 1'b0);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      drive(ADD, 1'b0, 1'b0, 1'b0);
      #1;
      n_total++;
      if (strobes !== exp_strobes() || bus.icount !== m_icount)
        $display("FAIL rst_mid_pre c=%0d strobes=%b want=%b icount=%0d want=%0d",
                 c, strobes, exp_strobes(), bus.icount, m_icount);
      else n_pass++;
      tick();
    end
    rst = 1'b1;
    drive(ADD, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    n_total++;
    if (strobes !== 7'b0 || bus.icount !== 16'd0 || bus.bus_err !== 1'b0)
      $display("FAIL rst_mid strobes=%b want=0 icount=%0d want=0 bus_err=%b want=0",
               strobes, bus.icount, bus.bus_err);
    else n_pass++;
  endtask

  task automatic test_random();
    opcode_t op;
    logic    ack;
    do_reset();
    op = ADD;
    for (int c = 0; c < 600; c++) begin
      if (m_ph == 0 && !m_halted) op = opcode_t'($urandom_range(0, 7));
      ack = WaitEn ? logic'($urandom_range(0, 4) != 0) : logic'($urandom_range(0, 1));
      drive(op, logic'($urandom_range(0, 1)), ack, logic'($urandom_range(0, 5) == 0));
      #1;
      n_total++;
      if (strobes !== exp_strobes() || bus.icount !== m_icount ||
          bus4.icount !== m_icount[3:0] || bus.bus_err !== m_bus_err)
        $display("FAIL random c=%0d op=%0d strobes=%b want=%b icount=%0d want=%0d bus_err=%b",
                 c, op, strobes, exp_strobes(), bus.icount, m_icount, bus.bus_err);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(ADD, 1'b0, 1'b1, 1'b0);
    test_reset();
    test_all_opcodes();
    test_wrap();
    test_halt();
    test_resume_ignored();
    test_no_stall();
    if (WaitEn) begin
      test_stall();
      test_timeout();
    end
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
